fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the MIPS core, sitting directly upstream of the control unit. Holds the program counter, fetches 32-bit instructions through a ready-based instruction-memory handshake, presents the instruction and its opcode/funct fields to decode, and computes the next PC (sequential, BEQ target or J target) when the downstream datapath acknowledges the instruction. Also keeps a free-running retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] ignored (forced 0)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (= pc, word aligned)
- imem_ready  in  1  memory response valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- instr  out  32  latched instruction
- instr_valid  out  1  instr/Op/Funct/instr_pc valid for decode
- Op  out  6  instr[31:26], to control unit
- Funct  out  6  instr[5:0], to control unit
- instr_pc  out  32  address of the latched instruction
- pc_plus4  out  32  instr_pc + 4 (mod 2^32)
- instr_ack  in  1  datapath has executed the instruction; PC advances
- Branch  in  1  from control unit
- Zero  in  1  ALU zero flag
- Jump  in  1  from control unit
- retired_count  out  32  instructions acknowledged since reset

## Operation
- States: BOOT, FETCH, VALID.
- Reset (async, rst_n=0): state=BOOT, pc=RESET_PC with [1:0]=00, instr=0, instr_valid=0, imem_req=0, retired_count=0. Op/Funct/instr_pc/pc_plus4 follow the reset registers (0, 0, RESET_PC, RESET_PC+4).
- BOOT: imem_req=0; next edge -> FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc held stable until accepted; instr_valid=0. Edge with imem_ready=1: instr<=imem_rdata, -> VALID. imem_ready=0: stay (unbounded wait states).
- VALID: imem_req=0, instr_valid=1, outputs stable. Edge with instr_ack=1: pc<=next_pc, retired_count+=1 (wraps at 2^32), -> FETCH. instr_ack=0: hold indefinitely.
- next_pc priority: Jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch&Zero -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4. Jump wins if Jump and Branch both asserted.
- Arithmetic in 32 bits, carries discarded: 0xFFFF_FFFC + 4 = 0x0000_0000; negative branch offsets wrap.
- Branch/Zero/Jump sampled only on the acknowledging edge in VALID; ignored otherwise.
- instr_ack outside VALID ignored (no PC change, no count). imem_ready outside FETCH ignored.
- Reset mid-wait (FETCH or VALID): abandons the outstanding request/instruction, returns to BOOT with RESET_PC; a late imem_ready after reset release is ignored because BOOT does not request.

## Timing
- First imem_req: first rising edge after rst_n release enters FETCH; imem_req=1 from that cycle.
- Zero-wait memory: FETCH cycle t (ready=1) -> instr_valid=1 in t+1; ack in t+1 -> FETCH with new pc in t+2. Throughput max 1 instruction / 2 cycles.
- Each memory wait cycle adds 1 cycle; each cycle ack is withheld adds 1 cycle.
- imem_addr changes only on the edge leaving VALID via ack, or on reset.
- All outputs registered or derived from registers only; no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0, clk running -> imem_req=0, instr_valid=0, retired_count=0, instr_pc=0x0; release -> one BOOT cycle, then imem_req=1, imem_addr=0x0.
- Sequential: zero-wait memory returning 0x0000_0020 (add), ack immediately, 4 instructions -> addresses 0x0,0x4,0x8,0xC, instr_valid 1 every other cycle, Op=0, Funct=0x20, retired_count=4.
- BEQ taken/not: instr 0x1000_FFFE at 0x10, Branch=1 Zero=1 -> next addr 0x0C; same with Zero=0 -> 0x14.
- Jump and priority: instr 0x0800_0040 at 0x20, Jump=1 and Branch=Zero=1 -> next addr 0x100.
- Wait states and back-pressure: imem_ready low 3 cycles, ack delayed 2 cycles -> addr stable throughout, instr_valid held, exactly one count increment.
- Wrap and reset mid-operation: RESET_PC=0xFFFF_FFFC, sequential ack -> next addr 0x0; pulse rst_n low during FETCH with ready pending -> returns to 0xFFFF_FFFC, retired_count=0, stale ready ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage with ready-handshake imem port and next-PC select
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  output logic [31:0] retired_count
);
  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
  typedef enum logic [1:0] {BOOT, FETCH, VALID} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, next_pc, br_off;
  assign imem_req    = state == FETCH;
  assign instr_valid = state == VALID;
  assign imem_addr   = pc;
  assign instr_pc    = pc;
  assign pc_plus4    = pc + 32'd4;
  assign Op          = instr[31:26];
  assign Funct       = instr[5:0];
  assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};
  always_comb begin
    next_pc = Jump ? {pc_plus4[31:28], instr[25:0], 2'b00}
            : (Branch && Zero) ? pc_plus4 + br_off : pc_plus4;
    state_nxt = state == BOOT ? FETCH
              : state == FETCH ? (imem_ready ? VALID : FETCH)
              : (instr_ack ? FETCH : VALID);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RST_PC;
      instr         <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ready) instr <= imem_rdata;
      if (state == VALID && instr_ack) begin
        pc            <= next_pc;
        retired_count <= retired_count + 32'd1;
      end
    end
  end
endmodule
